ovl_bus_turnaround_arbiter: RTL and testbench

//  Round-robin controller for a shared multi-driver bus. Drives driver_enables so at most one

---
 rtl/ovl_bus_arb_pkg.sv | 28 ++
 rtl/ovl_rr_pick.sv | 31 +++
 rtl/ovl_bus_turnaround_arbiter.sv | 136 +++++++++++++
 tb/tb_ovl_bus_turnaround_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ovl_bus_arb_pkg.sv
// Shared types and helpers for the bus turnaround arbiter.
package ovl_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    QUIET = 2'd2
  } arb_state_e;

  // Parameter floors. Out-of-range values are clamped up to these.
  localparam int MIN_NUM_DRIVERS = 2;
  localparam int MIN_QUIET_FLOOR = 1;

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // (base + ofs) mod n, for base < n and ofs < n.
  function automatic int wrap_idx(input int base, input int ofs, input int n);
    int s;
    s = base + ofs;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/ovl_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module ovl_rr_pick
  import ovl_bus_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_start,
  output logic                 o_found,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_j;

  // Scan from the farthest candidate back to i_start so the nearest set bit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'(wrap_idx(int'(i_start), k, N));
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/ovl_bus_turnaround_arbiter.sv
// Round-robin owner of a shared multi-driver bus with a mandatory quiet
// turnaround between owners. All outputs are registered.
module ovl_bus_turnaround_arbiter
  import ovl_bus_arb_pkg::*;
#(
  parameter int NUM_DRIVERS = 2,
  parameter int MIN_QUIET   = 1,
  parameter int MAX_QUIET   = 1,
  parameter int MAX_HOLD    = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_DRIVERS-1:0]         req,
  output logic [NUM_DRIVERS-1:0]         driver_enables,
  output logic [$clog2(NUM_DRIVERS)-1:0] owner,
  output logic                           bus_quiet,
  output logic                           hold_timeout
);

  localparam int N     = (NUM_DRIVERS < MIN_NUM_DRIVERS) ? MIN_NUM_DRIVERS : NUM_DRIVERS;
  localparam int IW    = $clog2(N);
  localparam int MIN_Q = (MIN_QUIET < MIN_QUIET_FLOOR) ? MIN_QUIET_FLOOR : MIN_QUIET;
  localparam int MAX_Q = (MAX_QUIET < MIN_Q) ? MIN_Q : MAX_QUIET;
  localparam int QW    = cnt_w(MAX_Q);
  localparam int HW    = cnt_w(MAX_HOLD);

  localparam logic [QW-1:0] Q_MIN   = QW'(MIN_Q);
  localparam logic [QW-1:0] Q_MAX   = QW'(MAX_Q);
  localparam logic [HW-1:0] H_LAST  = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic          HOLD_EN = (MAX_HOLD > 0);

  arb_state_e    r_state, w_state_nxt;
  logic [N-1:0]  r_en, w_en_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [QW-1:0] r_qcnt, w_qcnt_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic          r_quiet, w_quiet_nxt;
  logic          r_hto, w_hto_nxt;

  logic [IW-1:0] w_start;
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic          w_grant;
  logic          w_hold_hit;

  // Previous owner gets lowest priority: search begins one past it.
  assign w_start = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

  ovl_rr_pick #(.N(N)) u_pick (
    .i_req   (req[N-1:0]),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_grant    = enable & w_found;
  assign w_hold_hit = HOLD_EN && (r_hcnt == H_LAST);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_owner_nxt = r_owner;
    w_qcnt_nxt  = r_qcnt;
    w_hcnt_nxt  = r_hcnt;
    w_hto_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt        = OWN;
          w_en_nxt           = '0;
          w_en_nxt[w_idx]    = 1'b1;
          w_owner_nxt        = w_idx;
          w_hcnt_nxt         = '0;
        end
      end
      OWN: begin
        w_hcnt_nxt = r_hcnt + 1'b1;
        // A release in the same cycle as a new request always wins; the
        // request is served from QUIET once the minimum gap has elapsed.
        if (!req[r_owner] || w_hold_hit) begin
          w_state_nxt = QUIET;
          w_en_nxt    = '0;
          w_qcnt_nxt  = QW'(1);
          w_hto_nxt   = w_hold_hit;
        end
      end
      QUIET: begin
        if ((r_qcnt >= Q_MIN) && w_grant) begin
          w_state_nxt     = OWN;
          w_en_nxt        = '0;
          w_en_nxt[w_idx] = 1'b1;
          w_owner_nxt     = w_idx;
          w_hcnt_nxt      = '0;
        end else if (r_qcnt == Q_MAX) begin
          w_state_nxt = IDLE;
        end else begin
          w_qcnt_nxt = r_qcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_en_nxt    = '0;
      end
    endcase
    w_quiet_nxt = (w_state_nxt != OWN);
  end

  // State, counter and output registers; reset drops enables on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_en    <= '0;
      r_owner <= '0;
      r_qcnt  <= '0;
      r_hcnt  <= '0;
      r_quiet <= 1'b1;
      r_hto   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= w_en_nxt;
      r_owner <= w_owner_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_quiet <= w_quiet_nxt;
      r_hto   <= w_hto_nxt;
    end
  end

  assign driver_enables = r_en;
  assign owner          = r_owner;
  assign bus_quiet      = r_quiet;
  assign hold_timeout   = r_hto;

endmodule

// File: tb/tb_ovl_bus_turnaround_arbiter.sv
// Bench for ovl_bus_turnaround_arbiter: two configurations checked against a
// cycle-level reference model of the ownership/gap rules.
module tb_ovl_bus_turnaround_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // Config A: N=2, MIN=MAX=1, unlimited hold
  logic       en_a;
  logic [1:0] req_a, de_a;
  logic [0:0] own_a;
  logic       bq_a, to_a;
  // Config B: N=3, MIN=2, MAX=4, MAX_HOLD=4
  logic       en_b;
  logic [2:0] req_b, de_b;
  logic [1:0] own_b;
  logic       bq_b, to_b;

  int n_chk  = 0;
  int n_pass = 0;

  ovl_bus_turnaround_arbiter #(.NUM_DRIVERS(2), .MIN_QUIET(1), .MAX_QUIET(1), .MAX_HOLD(0)) dut_a (
    .clock(clk), .reset(rst_n), .enable(en_a), .req(req_a),
    .driver_enables(de_a), .owner(own_a), .bus_quiet(bq_a), .hold_timeout(to_a));

  ovl_bus_turnaround_arbiter #(.NUM_DRIVERS(3), .MIN_QUIET(2), .MAX_QUIET(4), .MAX_HOLD(4)) dut_b (
    .clock(clk), .reset(rst_n), .enable(en_b), .req(req_b),
    .driver_enables(de_b), .owner(own_b), .bus_quiet(bq_b), .hold_timeout(to_b));

  // Reference model: cur = owning driver (-1 none), last = most recent owner,
  // hold = cycles owned so far, gap = quiet cycles elapsed (0 = nothing owed).
  int m_cur[2], m_last[2], m_hold[2], m_gap[2];
  bit m_to[2];

  task automatic model_step(input int d, input int n, input int mn, input int mx, input int hd,
                            input bit en, input logic [3:0] rq, input bit rst_ok);
    int w;
    if (!rst_ok) begin
      m_cur[d] = -1; m_last[d] = 0; m_hold[d] = 0; m_gap[d] = 0; m_to[d] = 1'b0;
      return;
    end
    m_to[d] = 1'b0;
    if (m_cur[d] >= 0) begin
      if (!rq[m_cur[d]] || (hd != 0 && m_hold[d] == hd)) begin
        m_to[d]  = (hd != 0 && m_hold[d] == hd);
        m_cur[d] = -1;
        m_gap[d] = 1;
      end else begin
        m_hold[d]++;
      end
    end else begin
      w = -1;
      if (en && (m_gap[d] == 0 || m_gap[d] >= mn))
        for (int k = 1; k <= n; k++)
          if (w < 0 && rq[(m_last[d] + k) % n]) w = (m_last[d] + k) % n;
      if (w >= 0) begin
        m_cur[d] = w; m_last[d] = w; m_hold[d] = 1; m_gap[d] = 0;
      end else if (m_gap[d] != 0) begin
        m_gap[d] = (m_gap[d] == mx) ? 0 : m_gap[d] + 1;
      end
    end
  endtask

  function automatic logic [4:0] exp_a();
    logic [1:0] e;
    e = '0;
    if (m_cur[0] >= 0) e[m_cur[0]] = 1'b1;
    return {e, 1'(m_last[0]), (m_cur[0] < 0), m_to[0]};
  endfunction

  function automatic logic [6:0] exp_b();
    logic [2:0] e;
    e = '0;
    if (m_cur[1] >= 0) e[m_cur[1]] = 1'b1;
    return {e, 2'(m_last[1]), (m_cur[1] < 0), m_to[1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, 2, 1, 1, 0, en_a, {2'b00, req_a}, rst_n);
    model_step(1, 3, 2, 4, 4, en_b, {1'b0, req_b}, rst_n);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_a = 1'b0; req_a = '0; en_b = 1'b0; req_b = '0;
    tick(); tick();
    n_chk++;
    if ({de_a, own_a, bq_a, to_a} !== 5'b00010)
      $display("FAIL reset_a: got %b want %b", {de_a, own_a, bq_a, to_a}, 5'b00010);
    else n_pass++;
    n_chk++;
    if ({de_b, own_b, bq_b, to_b} !== 7'b0000010)
      $display("FAIL reset_b: got %b want %b", {de_b, own_b, bq_b, to_b}, 7'b0000010);
    else n_pass++;
    n_chk++;
    if ({de_b, own_b, bq_b, to_b} !== exp_b())
      $display("FAIL reset_b_model: got %b want %b", {de_b, own_b, bq_b, to_b}, exp_b());
    else n_pass++;
  endtask

  task automatic test_grant_latency();
    rst_n = 1'b1; en_a = 1'b1; req_a = 2'b01; en_b = 1'b1; req_b = '0;
    n_chk++;
    if (de_a !== 2'b00) $display("FAIL latency_pre: got %b want 00", de_a);
    else n_pass++;
    tick();
    n_chk++;
    if ({de_a, own_a, bq_a} !== 4'b0100)
      $display("FAIL latency_grant: got %b want 0100", {de_a, own_a, bq_a});
    else n_pass++;
    n_chk++;
    if ({de_a, own_a, bq_a, to_a} !== exp_a())
      $display("FAIL latency_model: got %b want %b", {de_a, own_a, bq_a, to_a}, exp_a());
    else n_pass++;
  endtask

  task automatic test_handoff();
    logic [1:0] rq_seq [3] = '{2'b11, 2'b10, 2'b10};
    logic [3:0] want   [3] = '{4'b0100, 4'b0001, 4'b1010};  // {enables, owner, quiet}
    for (int i = 0; i < 3; i++) begin
      req_a = rq_seq[i];
      tick();
      n_chk++;
      if ({de_a, own_a, bq_a} !== want[i])
        $display("FAIL handoff[%0d]: got %b want %b", i, {de_a, own_a, bq_a}, want[i]);
      else n_pass++;
      n_chk++;
      if ({de_a, own_a, bq_a, to_a} !== exp_a())
        $display("FAIL handoff_model[%0d]: got %b want %b", i, {de_a, own_a, bq_a, to_a}, exp_a());
      else n_pass++;
    end
  endtask

  task automatic test_hold_timeout();
    logic [2:0] want_de [11] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                                 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    logic       want_to [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    req_b = 3'b011;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_chk++;
      if ({de_b, to_b} !== {want_de[i], want_to[i]})
        $display("FAIL hold[%0d]: got %b want %b", i, {de_b, to_b}, {want_de[i], want_to[i]});
      else n_pass++;
      n_chk++;
      if ({de_b, own_b, bq_b, to_b} !== exp_b())
        $display("FAIL hold_model[%0d]: got %b want %b", i, {de_b, own_b, bq_b, to_b}, exp_b());
      else n_pass++;
    end
  endtask

  task automatic test_quiet_window();
    logic [2:0] rq_seq  [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010};
    logic [3:0] want    [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                                4'b0001, 4'b0001, 4'b0100};  // {enables, quiet}
    for (int i = 0; i < 8; i++) begin
      req_b = rq_seq[i];
      tick();
      n_chk++;
      if ({de_b, bq_b} !== want[i])
        $display("FAIL quiet[%0d]: got %b want %b", i, {de_b, bq_b}, want[i]);
      else n_pass++;
      n_chk++;
      if ({de_b, own_b, bq_b, to_b} !== exp_b())
        $display("FAIL quiet_model[%0d]: got %b want %b", i, {de_b, own_b, bq_b, to_b}, exp_b());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_own();
    n_chk++;
    if (de_a !== 2'b10) $display("FAIL rst_mid_pre: got %b want 10", de_a);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++;
    if ({de_a, own_a, bq_a} !== 4'b0001)
      $display("FAIL rst_mid_drop: got %b want 0001", {de_a, own_a, bq_a});
    else n_pass++;
    rst_n = 1'b1; req_a = 2'b10; en_a = 1'b1;
    tick();
    n_chk++;
    if ({de_a, own_a} !== 3'b101)
      $display("FAIL rst_mid_regrant: got %b want 101", {de_a, own_a});
    else n_pass++;
    n_chk++;
    if ({de_b, own_b, bq_b, to_b} !== exp_b())
      $display("FAIL rst_mid_b_model: got %b want %b", {de_b, own_b, bq_b, to_b}, exp_b());
    else n_pass++;
  endtask

  task automatic test_enable_gate();
    logic       en_seq [6] = '{0, 0, 0, 0, 1, 0};
    logic [2:0] want   [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010}; // {enables, quiet}
    req_a = 2'b01;
    for (int i = 0; i < 6; i++) begin
      en_a = en_seq[i];
      tick();
      n_chk++;
      if ({de_a, bq_a} !== want[i])
        $display("FAIL enable_gate[%0d]: got %b want %b", i, {de_a, bq_a}, want[i]);
      else n_pass++;
      n_chk++;
      if ({de_a, own_a, bq_a, to_a} !== exp_a())
        $display("FAIL enable_model[%0d]: got %b want %b", i, {de_a, own_a, bq_a, to_a}, exp_a());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0] prev_a;
    logic [2:0] prev_b;
    prev_a = de_a; prev_b = de_b;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req_a = 2'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 3'($urandom);
      en_a  = ($urandom_range(0, 7) != 0);
      en_b  = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      n_chk++;
      if ({de_a, own_a, bq_a, to_a} !== exp_a())
        $display("FAIL rand_a c=%0d: got %b want %b", c, {de_a, own_a, bq_a, to_a}, exp_a());
      else n_pass++;
      n_chk++;
      if ({de_b, own_b, bq_b, to_b} !== exp_b())
        $display("FAIL rand_b c=%0d: got %b want %b", c, {de_b, own_b, bq_b, to_b}, exp_b());
      else n_pass++;
      n_chk++;
      if (!$onehot0(de_a) || !$onehot0(de_b))
        $display("FAIL rand_onehot c=%0d: got a=%b b=%b want one-hot or zero", c, de_a, de_b);
      else n_pass++;
      n_chk++;
      if ((prev_a != 0 && de_a != 0 && de_a != prev_a) || (prev_b != 0 && de_b != 0 && de_b != prev_b))
        $display("FAIL rand_direct_switch c=%0d: got a %b->%b b %b->%b want a quiet gap",
                 c, prev_a, de_a, prev_b, de_b);
      else n_pass++;
      prev_a = de_a; prev_b = de_b;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = -1; m_last[d] = 0; m_hold[d] = 0; m_gap[d] = 0; m_to[d] = 1'b0;
    end
    test_reset();
    test_grant_latency();
    test_handoff();
    test_hold_timeout();
    test_quiet_window();
    test_reset_mid_own();
    test_enable_gate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
